i2c_bus_frontend: RTL and testbench



---
 rtl/i2c_bus_frontend.sv | 193 +++++++++++++++++++
 tb/tb_i2c_bus_frontend.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_frontend.sv
// I2C slave bus front end: pin synchronisation, SCL edge and START/STOP detection,
// 7-bit address match, ACK drive on open-drain SDA and write-data enable for the receiver.
module i2c_bus_frontend #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_sync_o,
    output logic scl_pos_edge_detected_o,
    output logic scl_neg_edge_detected_o,
    output logic start_detected_o,
    output logic stop_detected_o,
    output logic addr_match_o,
    output logic rw_o,
    output logic data_en_o,
    output logic sda_pull_low_o,
    output logic busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WDATA,
        ST_WACK,
        ST_PASSIVE
    } state_t;

    logic scl_sync1, scl_sync2, scl_hist;
    logic sda_sync1, sda_sync2, sda_hist;

    // Everything resets to the idle-high bus level so leaving reset never
    // manufactures an SCL edge, START or STOP.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            {scl_sync1, scl_sync2, scl_hist} <= 3'b111;
            {sda_sync1, sda_sync2, sda_hist} <= 3'b111;
        end else begin
            // NOTE: non-blocking assignments so each stage samples the previous stage's pre-edge value.
            scl_sync1 <= scl_i;
            scl_sync2 <= scl_sync1;
            scl_hist  <= scl_sync2;
            sda_sync1 <= sda_i;
            sda_sync2 <= sda_sync1;
            sda_hist  <= sda_sync2;
        end
    end

    logic scl_pos, scl_neg, sda_pos, sda_neg, start_det, stop_det;

    assign scl_pos   = scl_sync2 & ~scl_hist;
    assign scl_neg   = ~scl_sync2 & scl_hist;
    assign sda_pos   = sda_sync2 & ~sda_hist;
    assign sda_neg   = ~sda_sync2 & sda_hist;
    assign start_det = sda_neg & scl_sync2;
    assign stop_det  = sda_pos & scl_sync2;

    state_t      state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        pull_q, pull_d;
    logic        den_q, den_d;
    logic        match_q, match_d;
    logic        rw_q, rw_d;
    logic        busy_q, busy_d;

    always_comb begin
        // NOTE: every *_d gets its hold value first; a missing default here would infer a latch.
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        pull_d  = pull_q;
        den_d   = den_q;
        match_d = match_q;
        rw_d    = rw_q;
        busy_d  = busy_q;

        if (start_det || stop_det) begin
            // Bus conditions win over any SCL edge in the same cycle.
            state_d = start_det ? ST_ADDR : ST_IDLE;
            shift_d = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
            pull_d  = 1'b0;
            den_d   = 1'b0;
            match_d = 1'b0;
            rw_d    = 1'b0;
            busy_d  = start_det;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_pos && !done_q) begin
                        shift_d = {shift_q[6:0], sda_sync2};
                        cnt_d   = cnt_q + 3'd1;
                        done_d  = (cnt_q == 3'd7);
                    end else if (scl_neg && done_q) begin
                        done_d = 1'b0;
                        cnt_d  = '0;
                        if (shift_q[7:1] == SLAVE_ADDR) begin
                            state_d = ST_ADDR_ACK;
                            pull_d  = 1'b1;
                            match_d = 1'b1;
                            rw_d    = shift_q[0];
                        end else begin
                            state_d = ST_PASSIVE;
                            pull_d  = 1'b0;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_neg) begin
                        pull_d = 1'b0;
                        if (!rw_q) begin
                            state_d = ST_WDATA;
                            den_d   = 1'b1;
                            cnt_d   = '0;
                            done_d  = 1'b0;
                        end else begin
                            // Reads are served by a separate block; stay off the bus.
                            state_d = ST_PASSIVE;
                        end
                    end
                end
                ST_WDATA: begin
                    if (scl_neg) begin
                        if (cnt_q == 3'd7) begin
                            state_d = ST_WACK;
                            pull_d  = 1'b1;
                            cnt_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                ST_WACK: begin
                    // data_en stays high so the receiver's bit counter keeps its 9-bit framing.
                    if (scl_neg) begin
                        state_d = ST_WDATA;
                        pull_d  = 1'b0;
                        cnt_d   = '0;
                        done_d  = 1'b0;
                    end
                end
                ST_IDLE, ST_PASSIVE: begin
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            pull_q  <= 1'b0;
            den_q   <= 1'b0;
            match_q <= 1'b0;
            rw_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            pull_q  <= pull_d;
            den_q   <= den_d;
            match_q <= match_d;
            rw_q    <= rw_d;
            busy_q  <= busy_d;
        end
    end

    assign sda_sync_o              = sda_sync2;
    assign scl_pos_edge_detected_o = scl_pos;
    assign scl_neg_edge_detected_o = scl_neg;
    assign start_detected_o        = start_det;
    assign stop_detected_o         = stop_det;
    assign addr_match_o            = match_q;
    assign rw_o                    = rw_q;
    assign data_en_o               = den_q;
    assign sda_pull_low_o          = pull_q;
    assign busy_o                  = busy_q;

endmodule

// File: tb/tb_i2c_bus_frontend.sv
// Scoreboard bench for i2c_bus_frontend: a bus master drives randomized transfers and
// queues the expected bus view per SCL rise; a monitor pops and compares on DUT pulses.
module tb_i2c_bus_frontend;

    localparam logic [6:0] SLAVE = 7'h50;

    logic clk_i = 1'b0;
    logic reset_i, scl_i, sda_drv, sda_i;
    logic sda_sync_o, scl_pos_edge_detected_o, scl_neg_edge_detected_o;
    logic start_detected_o, stop_detected_o, addr_match_o, rw_o;
    logic data_en_o, sda_pull_low_o, busy_o;

    // Open-drain wire: master and slave can only pull low.
    assign sda_i = sda_drv & ~sda_pull_low_o;

    i2c_bus_frontend #(.SLAVE_ADDR(SLAVE)) dut (
        .clk_i                   (clk_i),
        .reset_i                 (reset_i),
        .scl_i                   (scl_i),
        .sda_i                   (sda_i),
        .sda_sync_o              (sda_sync_o),
        .scl_pos_edge_detected_o (scl_pos_edge_detected_o),
        .scl_neg_edge_detected_o (scl_neg_edge_detected_o),
        .start_detected_o        (start_detected_o),
        .stop_detected_o         (stop_detected_o),
        .addr_match_o            (addr_match_o),
        .rw_o                    (rw_o),
        .data_en_o               (data_en_o),
        .sda_pull_low_o          (sda_pull_low_o),
        .busy_o                  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef enum int {EV_BIT, EV_START, EV_STOP} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        bit sda, pull, den, am, rw;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] exp_bytes[$];
    int errors = 0;
    int checks = 0;

    // Transfer context of the reference model
    bit cur_match, cur_rw, in_xfer;
    int cur_idx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Bus view while bit number idx of a transfer is on the wire:
    // 0..7 address, 8 address ACK, then 9-bit groups of data + ACK.
    function automatic ev_t bit_status(input int idx, input bit drv);
        ev_t e;
        e.kind = EV_BIT;
        e.pull = 1'b0; e.den = 1'b0; e.am = 1'b0; e.rw = 1'b0;
        if (idx == 8) begin
            e.pull = cur_match;
            e.am   = cur_match;
            e.rw   = cur_match & cur_rw;
        end else if (idx > 8) begin
            if (cur_match && !cur_rw) begin
                e.den  = 1'b1;
                e.am   = 1'b1;
                e.pull = ((idx - 9) % 9 == 8);
            end else begin
                e.am = cur_match;
                e.rw = cur_match & cur_rw;
            end
        end
        e.sda = drv & ~e.pull;
        return e;
    endfunction

    function automatic ev_t cond_ev(input ev_kind_e k);
        ev_t e;
        e.kind = k;
        e.sda = 1'b0; e.pull = 1'b0; e.den = 1'b0; e.am = 1'b0; e.rw = 1'b0;
        return e;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic send_bit(input bit drv);
        int q, h;
        q = $urandom_range(3, 5);
        h = $urandom_range(6, 10);
        sda_drv = drv;
        wait_clk(q);
        exp_q.push_back(bit_status(cur_idx, drv));
        scl_i = 1'b1;
        wait_clk(h);
        scl_i = 1'b0;
        cur_idx++;
        wait_clk(q);
    endtask

    task automatic bus_start();
        if (scl_i == 1'b0) begin
            sda_drv = 1'b1;
            wait_clk(3);
            exp_q.push_back(bit_status(cur_idx, 1'b1));
            scl_i = 1'b1;
            wait_clk(4);
        end
        exp_q.push_back(cond_ev(EV_START));
        sda_drv = 1'b0;
        wait_clk(4);
        scl_i = 1'b0;
        wait_clk(3);
        cur_idx = 0;
        in_xfer = 1'b1;
    endtask

    task automatic bus_stop();
        sda_drv = 1'b0;
        wait_clk(3);
        exp_q.push_back(bit_status(cur_idx, 1'b0));
        scl_i = 1'b1;
        wait_clk(4);
        exp_q.push_back(cond_ev(EV_STOP));
        sda_drv = 1'b1;
        wait_clk(6);
        in_xfer = 1'b0;
    endtask

    task automatic send_addr(input logic [6:0] a, input bit rw);
        logic [7:0] b;
        cur_match = (a == SLAVE);
        cur_rw    = rw;
        b = {a, rw};
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        send_bit(1'b1);
    endtask

    task automatic send_data_bits(input logic [7:0] d, input bit push_exp);
        if (push_exp && cur_match && !cur_rw) exp_bytes.push_back(d);
        for (int i = 7; i >= 0; i--) send_bit(cur_rw ? 1'b1 : d[i]);
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_data_bits(d, 1'b1);
        send_bit(1'b1);
    endtask

    task automatic send_partial(input int n);
        for (int i = 0; i < n; i++) send_bit(cur_rw ? 1'b1 : 1'($urandom_range(0, 1)));
    endtask

    // Monitor: compares every DUT-presented event against the head of the scoreboard.
    initial begin
        int rx_cnt;
        logic [7:0] rx_byte;
        bit clr_pend, clr_busy;
        ev_t e;
        rx_cnt = 0; rx_byte = '0; clr_pend = 0; clr_busy = 0;
        forever begin
            @(negedge clk_i);
            if (reset_i) begin
                rx_cnt = 0;
                clr_pend = 0;
                continue;
            end
            if (clr_pend) begin
                check("cond_clear data_en", data_en_o, 0);
                check("cond_clear addr_match", addr_match_o, 0);
                check("cond_clear rw", rw_o, 0);
                check("cond_clear pull", sda_pull_low_o, 0);
                check("cond_clear busy", busy_o, clr_busy);
                clr_pend = 0;
            end
            if (start_detected_o || stop_detected_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected start_stop", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("cond_kind", int'(e.kind), start_detected_o ? int'(EV_START) : int'(EV_STOP));
                end
                clr_pend = 1;
                clr_busy = start_detected_o;
                rx_cnt = 0;
            end
            if (scl_pos_edge_detected_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected scl_pos", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("bit_kind", int'(e.kind), int'(EV_BIT));
                    if (e.kind == EV_BIT) begin
                        check("bit sda_sync", sda_sync_o, e.sda);
                        check("bit pull", sda_pull_low_o, e.pull);
                        check("bit data_en", data_en_o, e.den);
                        check("bit addr_match", addr_match_o, e.am);
                        check("bit rw", rw_o, e.rw);
                        check("bit busy", busy_o, 1);
                    end
                end
                if (data_en_o) begin
                    if (rx_cnt < 8) rx_byte = {rx_byte[6:0], sda_sync_o};
                    rx_cnt++;
                    if (rx_cnt == 8) begin
                        if (exp_bytes.size() == 0) check("unexpected rx byte", rx_byte, 'hFFFF);
                        else check("rx byte", rx_byte, exp_bytes.pop_front());
                    end
                    if (rx_cnt == 9) rx_cnt = 0;
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        reset_i = 1'b1;
        scl_i = 1'b1;
        sda_drv = 1'b1;
        cur_idx = 0; cur_match = 0; cur_rw = 0; in_xfer = 0;
        wait_clk(3);
        check("reset sda_sync", sda_sync_o, 1);
        check("reset pulses", {scl_pos_edge_detected_o, scl_neg_edge_detected_o,
                               start_detected_o, stop_detected_o}, 0);
        check("reset outputs", {addr_match_o, rw_o, data_en_o, sda_pull_low_o, busy_o}, 0);
        reset_i = 1'b0;
        wait_clk(4);

        // Matched write of 0xA5
        bus_start(); send_addr(SLAVE, 1'b0); send_byte(8'hA5); bus_stop();
        // Address 0x51: NACK, passive
        bus_start(); send_addr(7'h51, 1'b0); send_byte(8'h3C); bus_stop();
        // Matched read: ACK, then no drive
        bus_start(); send_addr(SLAVE, 1'b1); send_byte(8'hFF); send_byte(8'hFF); bus_stop();
        // Repeated START after 4 data bits, then a fresh matched write
        bus_start(); send_addr(SLAVE, 1'b0); send_partial(4);
        bus_start(); send_addr(SLAVE, 1'b0); send_byte(8'h3C); bus_stop();
        // STOP after 3 data bits
        bus_start(); send_addr(SLAVE, 1'b0); send_byte(8'h81); send_partial(3); bus_stop();

        // Reset during the data ACK bit
        bus_start(); send_addr(SLAVE, 1'b0);
        d = 8'($urandom);
        send_data_bits(d, 1'b1);
        sda_drv = 1'b1;
        wait_clk(2);
        check("ack pull before reset", sda_pull_low_o, 1);
        reset_i = 1'b1;
        wait_clk(1);
        check("reset mid ack pull", sda_pull_low_o, 0);
        check("reset mid ack outputs", {addr_match_o, rw_o, data_en_o, busy_o}, 0);
        scl_i = 1'b1;
        wait_clk(3);
        reset_i = 1'b0;
        in_xfer = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_clk(1);
            check("no pulse after reset", {scl_pos_edge_detected_o, scl_neg_edge_detected_o,
                                           start_detected_o, stop_detected_o}, 0);
        end
        check("scoreboard drained at reset", exp_q.size(), 0);

        // Randomized transfers
        for (int t = 0; t < 25; t++) begin
            logic [6:0] a;
            bit rw;
            int nb;
            a  = ($urandom_range(0, 2) != 0) ? SLAVE : 7'($urandom);
            rw = 1'($urandom_range(0, 1));
            nb = $urandom_range(0, 2);
            bus_start();
            send_addr(a, rw);
            for (int b = 0; b < nb; b++) send_byte(8'($urandom));
            send_partial($urandom_range(0, 6));
            if ($urandom_range(0, 1) == 1) bus_stop();
        end
        if (in_xfer) bus_stop();

        wait_clk(10);
        check("scoreboard drained", exp_q.size(), 0);
        check("rx bytes drained", exp_bytes.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
